// File: rtl/sdf3_frame_ctrl_pkg.sv
// Shared definitions for the radix-2^3 SDF stage frame controller.
// Contents: frame geometry and latency constants, the controller FSM
// state type and the per-beat marker entry carried alongside the stage
// pipeline.
package sdf_ctrl_pkg;

    localparam int N       = 512;
    localparam int LANES   = 16;
    localparam int BEATS   = N / LANES;
    localparam int LAT     = 6;
    localparam int CREDITS = 8;
    localparam int CW      = $clog2(CREDITS + 1);
    localparam int BW      = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One slot of the marker pipe that shadows the stage datapath.
    typedef struct packed {
        logic en;
        logic sop;
        logic eop;
        logic mode;
    } pipe_entry_t;

endpackage

// File: rtl/sdf3_frame_ctrl_if.sv
// Upstream beat handshake into the frame controller.
// Signals:
//   in_valid - upstream has a 16-sample beat available
//   in_mode  - fft_mode of the upstream frame (meaningful on its first beat)
//   in_ready - controller accepts the beat this cycle
// Handshake: a beat transfers in every cycle where in_valid and in_ready
// are both high; in_ready never depends on in_valid, and upstream keeps
// in_valid/in_mode stable until the transfer happens.
interface sdf3_frame_ctrl_if;
    logic in_valid;
    logic in_mode;
    logic in_ready;

    modport master (output in_valid, output in_mode, input in_ready);
    modport slave  (input in_valid, input in_mode, output in_ready);
endinterface

// File: rtl/sdf3_frame_ctrl_valid_pipe.sv
// Fixed-depth shift register of frame markers that runs in lock-step with
// the stage's internal latency.
// Ports:
//   clk, rst  - clock, synchronous active-high clear
//   d         - entry entering the pipe this cycle
//   tail      - entry leaving the pipe (DEPTH cycles after it entered)
//   any_valid - at least one stored entry has en set
module sdf_valid_pipe
    import sdf_ctrl_pkg::*;
#(
    parameter int DEPTH = LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  pipe_entry_t d,
    output pipe_entry_t tail,
    output logic        any_valid
);

    pipe_entry_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage_q[i].en;
        end
    end

    assign tail = stage_q[DEPTH-1];

endmodule

// File: rtl/sdf3_frame_ctrl.sv
// Frame sequencer for the 16-lane radix-2^3 SDF stage.
// Accepts beats from upstream, drives the stage input enable, beat index and
// per-frame fft_mode, and regenerates frame markers aligned to the stage
// output enable. Issue is gated on downstream credits because the stage
// cannot stall once a beat has entered.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   up         - upstream handshake (in_valid, in_mode, in_ready)
//   credit_ret - downstream freed one beat slot
//   st_en      - stage di_en (high exactly when a beat is accepted)
//   st_mode    - stage fft_mode, constant across a frame
//   st_beat    - index of the beat being issued
//   out_en     - mirror of stage do_en
//   out_sop    - first beat of a frame at the stage output
//   out_eop    - last beat of a frame at the stage output
//   out_mode   - mode of the frame at the stage output
//   busy       - a frame is open or beats are still in flight
//   dbg_state  - current controller state
module sdf3_frame_ctrl
    import sdf_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    sdf3_frame_ctrl_if.slave  up,
    input  logic              credit_ret,
    output logic              st_en,
    output logic              st_mode,
    output logic [BW-1:0]     st_beat,
    output logic              out_en,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_mode,
    output logic              busy,
    output state_t            dbg_state
);

    state_t        state_q;
    logic [CW-1:0] credit_q;
    logic [CW-1:0] credit_d;
    logic [BW-1:0] beat_q;
    logic          mode_q;

    logic          ready;
    logic          issue;
    logic          last_beat;
    logic          drain_req;
    logic          ret_ok;
    logic          pipe_any;
    pipe_entry_t   pipe_d;
    pipe_entry_t   pipe_tail;

    // A new frame with a different mode may not enter while beats of the
    // old mode are still inside the stage: hold it off and drain first.
    assign drain_req = (state_q == IDLE) && (up.in_mode != mode_q) && pipe_any;

    // rst gates ready so nothing issues while the registers are being cleared.
    assign ready = !rst && (state_q == IDLE || state_q == RUN)
                   && (credit_q != '0) && !drain_req;
    assign up.in_ready = ready;
    assign issue       = up.in_valid && ready;

    assign last_beat = (beat_q == BW'(BEATS - 1));

    // The stage samples fft_mode together with beat 0, so the requested mode
    // is forwarded in that cycle; afterwards the latched value holds.
    assign st_en   = issue;
    assign st_beat = beat_q;
    assign st_mode = (state_q == IDLE && issue) ? up.in_mode : mode_q;

    // Full counter ignores a further return.
    assign ret_ok = credit_ret && (credit_q != CW'(CREDITS));

    always_comb begin
        credit_d = credit_q;
        if (issue && !ret_ok) begin
            credit_d = credit_q - CW'(1);
        end else if (!issue && ret_ok) begin
            credit_d = credit_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= CW'(CREDITS);
            beat_q   <= '0;
            mode_q   <= 1'b0;
        end else begin
            credit_q <= credit_d;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        mode_q <= up.in_mode;
                        if (BEATS == 1) begin
                            beat_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            beat_q  <= BW'(1);
                            state_q <= RUN;
                        end
                    end else if (up.in_valid && drain_req) begin
                        state_q <= DRAIN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (last_beat) begin
                            // Back to IDLE so the next frame's mode is
                            // compared before its first beat issues.
                            beat_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!pipe_any) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        pipe_d      = '0;
        pipe_d.en   = issue;
        pipe_d.sop  = issue && (beat_q == '0);
        pipe_d.eop  = issue && last_beat;
        pipe_d.mode = issue && st_mode;
    end

    sdf_valid_pipe #(.DEPTH(LAT)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .d         (pipe_d),
        .tail      (pipe_tail),
        .any_valid (pipe_any)
    );

    assign out_en   = pipe_tail.en;
    assign out_sop  = pipe_tail.en && pipe_tail.sop;
    assign out_eop  = pipe_tail.en && pipe_tail.eop;
    assign out_mode = pipe_tail.en && pipe_tail.mode;

    assign busy      = (state_q != IDLE) || pipe_any;
    assign dbg_state = state_q;

    // A return with every slot already free means the downstream is out of
    // step with this controller.
    a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(credit_ret && credit_q == CW'(CREDITS)));

endmodule

// File: tb/tb_sdf3_frame_ctrl.sv
module tb_sdf3_frame_ctrl;
    import sdf_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          credit_ret;
    logic          st_en, st_mode;
    logic [BW-1:0] st_beat;
    logic          out_en, out_sop, out_eop, out_mode, busy;
    state_t        dbg_state;

    sdf3_frame_ctrl_if up_if ();

    sdf3_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .up         (up_if),
        .credit_ret (credit_ret),
        .st_en      (st_en),
        .st_mode    (st_mode),
        .st_beat    (st_beat),
        .out_en     (out_en),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_mode   (out_mode),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // exp_q holds the LAT most recent issue records {en,sop,eop,mode};
    // its head is what the stage output must show this cycle.
    logic [3:0] exp_q[$];
    int   m_credit;
    int   m_beat;      // beats already issued in the open frame
    bit   m_mode;      // mode of the current / last frame
    bit   m_drain;     // waiting for the stage to empty before a mode change
    bit   m_started = 1'b0;
    bit   inflight, boundary, blocked, exp_ready, exp_issue, exp_smode, ret_ok;
    logic [3:0] head, nentry;

    always @(negedge clk) begin
        if (rst) begin
            m_credit  = CREDITS;
            m_beat    = 0;
            m_mode    = 1'b0;
            m_drain   = 1'b0;
            m_started = 1'b1;
            exp_q.delete();
            for (int i = 0; i < LAT; i++) exp_q.push_back(4'b0);
        end else if (m_started) begin
            inflight = 1'b0;
            foreach (exp_q[i]) if (exp_q[i][3]) inflight = 1'b1;
            boundary  = (m_beat == 0) && !m_drain;
            blocked   = boundary && (up_if.in_mode != m_mode) && inflight;
            exp_ready = (m_credit > 0) && !m_drain && !blocked;
            exp_issue = up_if.in_valid && exp_ready;
            exp_smode = (m_beat == 0) ? up_if.in_mode : m_mode;

            check("in_ready", up_if.in_ready, exp_ready);
            check("st_en", st_en, exp_issue);
            if (exp_issue) begin
                check("st_beat", st_beat, m_beat);
                check("st_mode", st_mode, exp_smode);
            end
            head = exp_q[0];
            check("out_en", out_en, head[3]);
            check("out_sop", out_sop, head[2]);
            check("out_eop", out_eop, head[1]);
            check("out_mode", out_mode, head[0]);
            check("busy", busy, (m_beat != 0) || m_drain || inflight);

            if (m_drain && !inflight) m_drain = 1'b0;
            else if (blocked && up_if.in_valid) m_drain = 1'b1;

            nentry = 4'b0;
            if (exp_issue) begin
                nentry = {1'b1, m_beat == 0, m_beat == BEATS - 1, exp_smode};
                if (m_beat == 0) m_mode = up_if.in_mode;
                m_beat = (m_beat + 1) % BEATS;
            end
            ret_ok   = credit_ret && (m_credit < CREDITS);
            m_credit = m_credit - int'(exp_issue) + int'(ret_ok);
            void'(exp_q.pop_front());
            exp_q.push_back(nentry);
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit m, input bit r);
        up_if.in_valid = v;
        up_if.in_mode  = m;
        credit_ret     = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic bit auto_ret();
        return m_credit < CREDITS;
    endfunction

    // ---------------- stimulus ----------------
    int en_cnt, cnt, first_en, last_en, sop0, sop1, eop0, eop1, n_sop, n_eop;
    int a_last, b_first, a_eop, b_out, b_out_sop, low_cnt, issue_at, eop_at;
    bit ready_low, eop_seen, rmode;

    initial begin
        drive(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        // reset values while rst is held
        @(negedge clk);
        check("rst_in_ready", up_if.in_ready, 0);
        check("rst_st_en", st_en, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", dbg_state, IDLE);
        check("rst_busy", busy, 0);
        check("rst_out_en", out_en, 0);
        check("rst_st_beat", st_beat, 0);

        // T1: two same-mode frames back to back, credits recycled from cycle 6
        do_reset();
        en_cnt = 0; first_en = -1; last_en = -1; n_sop = 0; n_eop = 0;
        sop0 = -1; sop1 = -1; eop0 = -1; eop1 = -1;
        for (int i = 0; i < 72; i++) begin
            drive(i < 64, 0, (i >= 6) && (i < 70));
            @(negedge clk);
            if (st_en) begin
                en_cnt++;
                if (first_en < 0) first_en = i;
                last_en = i;
            end
            if (out_sop) begin
                if (n_sop == 0) sop0 = i; else sop1 = i;
                n_sop++;
            end
            if (out_eop) begin
                if (n_eop == 0) eop0 = i; else eop1 = i;
                n_eop++;
            end
            step();
        end
        check("t1_en_cnt", en_cnt, 64);
        check("t1_first_en", first_en, 0);
        check("t1_last_en", last_en, 63);
        check("t1_sop0", sop0, 6);
        check("t1_sop1", sop1, 38);
        check("t1_eop0", eop0, 37);
        check("t1_eop1", eop1, 69);

        // T2: no credit returns -> exactly CREDITS issues, then one return
        do_reset();
        en_cnt = 0; ready_low = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 0);
            @(negedge clk);
            if (st_en) en_cnt++;
            if (i >= 8 && up_if.in_ready) ready_low = 1'b0;
            step();
        end
        check("t2_issues", en_cnt, 8);
        check("t2_ready_low", ready_low, 1);
        en_cnt = 0; issue_at = -1;
        for (int i = 12; i < 17; i++) begin
            drive(1, 0, i == 12);
            @(negedge clk);
            if (st_en) begin
                en_cnt++;
                issue_at = i;
            end
            step();
        end
        check("t2_extra", en_cnt, 1);
        check("t2_extra_at", issue_at, 13);

        // T3: frame A mode 0, frame B mode 1 -> drain between them
        do_reset();
        cnt = 0; a_last = -1; b_first = -1; a_eop = -1; b_out = -1;
        b_out_sop = -1; low_cnt = 0;
        for (int i = 0; i < 200 && (cnt < 64 || i < b_first + LAT + 2); i++) begin
            drive(cnt < 64, cnt >= 32, auto_ret());
            @(negedge clk);
            if (a_last >= 0 && b_first < 0 && !up_if.in_ready) low_cnt++;
            if (st_en) begin
                if (st_beat == BW'(BEATS - 1) && !st_mode) a_last = i;
                if (st_beat == '0 && st_mode) b_first = i;
                cnt++;
            end
            if (out_eop && !out_mode) a_eop = i;
            if (out_en && out_mode && b_out < 0) begin
                b_out = i;
                b_out_sop = out_sop;
            end
            step();
        end
        check("t3_done", cnt, 64);
        check("t3_gap", b_first - a_last, LAT + 2);
        check("t3_after_eop", int'(b_first > a_eop && a_eop >= 0), 1);
        check("t3_ready_low", low_cnt, LAT + 1);
        check("t3_b_out", b_out - b_first, LAT);
        check("t3_mode_on_sop", b_out_sop, 1);

        // T4: in_valid toggling inside one frame
        do_reset();
        cnt = 0; n_eop = 0; eop_at = -1; issue_at = -1;
        for (int i = 0; i < 80; i++) begin
            drive((i % 2 == 0) && cnt < 32, 0, auto_ret());
            @(negedge clk);
            if (st_en) begin
                check("t4_beat", st_beat, cnt);
                issue_at = i;
                cnt++;
            end
            if (out_eop) begin
                n_eop++;
                eop_at = i;
            end
            step();
        end
        check("t4_issues", cnt, 32);
        check("t4_eop_n", n_eop, 1);
        check("t4_eop_at", eop_at - issue_at, LAT);

        // T5: reset in the middle of a frame
        do_reset();
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 17; i++) begin
            drive(1, 0, auto_ret());
            @(negedge clk);
            if (st_en) cnt++;
            step();
        end
        check("t5_pre", cnt, 17);
        rst = 1'b1;
        drive(0, 0, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t5_out_en", out_en, 0);
        check("t5_busy", busy, 0);
        check("t5_st_beat", st_beat, 0);
        check("t5_st_en", st_en, 0);
        step();
        en_cnt = 0; issue_at = -1; eop_seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            drive(1, 0, 0);
            @(negedge clk);
            if (st_en) begin
                if (issue_at < 0) begin
                    issue_at = i;
                    check("t5_first_beat", st_beat, 0);
                end
                en_cnt++;
            end
            if (out_eop) eop_seen = 1'b1;
            step();
        end
        check("t5_credits", en_cnt, 8);
        check("t5_no_eop", eop_seen, 0);

        // T6: return and issue in the same cycle at credit 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0);
            step();
        end
        drive(1, 0, 1);
        @(negedge clk);
        check("t6_issue", st_en, 1);
        step();
        en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0);
            @(negedge clk);
            if (i == 0) check("t6_ready", up_if.in_ready, 1);
            if (st_en) en_cnt++;
            step();
        end
        check("t6_left", en_cnt, 3);

        // Random traffic against the model
        do_reset();
        rmode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) rmode = ~rmode;
            drive($urandom_range(0, 3) != 0, rmode,
                  auto_ret() && ($urandom_range(0, 2) != 0));
            step();
        end
        rst = 1'b0;
        drive(0, 0, 0);
        repeat (LAT + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
